stream_packer: RTL and testbench
================================

Name: stream_packer

Overview:
- Width up-converter placed directly downstream of pipe_stage.
- Accepts a WIDTH-bit valid/ready beat stream and packs RATIO consecutive beats into one WIDTH*RATIO-bit output word.
- An input last flag closes a word early; the word goes out partially filled, with a keep mask and its own last flag.
- Full throughput: one input beat per cycle, no bubbles while the consumer is ready.

Parameters:
- WIDTH, 8, input beat width in bits.
- RATIO, 4, input beats per output word (>=2).
- TIMEOUT, 16, idle cycles before a partial word is flushed (used only with the optional feature).

Ports:
- clk  in  1  clock
- i_reset_n  in  1  synchronous, active-low reset
- i_data  in  WIDTH  input beat
- i_last  in  1  beat closes the current word/packet
- i_vld  in  1  input valid
- o_rdy  out  1  input ready
- o_data  out  WIDTH*RATIO  packed word
- o_keep  out  RATIO  per-lane valid mask
- o_last  out  1  word closed by i_last
- o_vld  out  1  output valid
- i_rdy  in  1  downstream ready

Behaviour:
- Handshakes: input accepted when i_vld && o_rdy; output consumed when o_vld && i_rdy. o_vld/o_data/o_keep/o_last stay stable while o_vld && !i_rdy.
- State:
  - Accumulator: acc_data, acc_keep, acc_cnt (0..RATIO-1), acc_last, acc_done.
  - One output register: out_*, out_vld.
- Packing:
  - Little-endian: beat k of a word lands in o_data[k*WIDTH +: WIDTH] and sets o_keep[k].
  - Unfilled lanes: data 0, keep 0.
- Word completion: an accepted beat completes the word when acc_cnt==RATIO-1 or i_last=1.
  - If the output slot is free (!out_vld) or draining this cycle (o_vld && i_rdy), the completed word loads the output register next cycle. Accumulator clears and acc_cnt returns to 0.
  - Otherwise the completed word is held in the accumulator with acc_done=1.
  - While acc_done=1, it moves to the output register on the first cycle the slot is free or draining, then acc_done clears.
- o_rdy = !acc_done. Combinational from registers only, never from i_vld or i_rdy.
- Latency: completing beat accepted in cycle t gives o_vld=1 in cycle t+1.
- Sustained rate: 1 word per RATIO cycles with i_rdy held high.
- o_last = acc_last of the transferred word. A word filled to RATIO beats with i_last on the final beat has o_last=1 and o_keep all ones.
- Single-beat packet (i_last on beat 0): o_keep = 1 in lane 0 only.
- Output stall: at most one completed word plus the output word are buffered; further input is back-pressured by o_rdy=0.
- Reset, including mid-packet:
  - Accumulator and output register clear: o_vld=0, o_data=0, o_keep=0, o_last=0.
  - acc_cnt=0, acc_done=0, o_rdy=1 from the first cycle after reset.
  - Partial data is discarded.

Optional Feature:
- Macro STREAM_PACKER_TIMEOUT_EN.
- Defined:
  - Idle counter increments each cycle that acc_cnt>0, acc_done=0 and no beat is accepted; it resets to 0 on any accepted beat.
  - When it reaches TIMEOUT, the partial word is marked acc_done with acc_last=0 and is then emitted under the normal transfer rules.
- Not defined: partial words wait indefinitely for more beats or i_last. No counter logic is present.

Decomposition:
- Package stream_pkg:
  - keep-mask typedef.
  - Lane-offset helper function (lane index times WIDTH).
  - Default WIDTH/RATIO constants shared with pipe_stage benches.
- Sub-module pack_idle_timer: the timeout counter, instantiated only under STREAM_PACKER_TIMEOUT_EN. Packing logic stays in one module.

Test Plan:
- Reset, then 8 beats 0x01..0x08, no i_last, i_rdy=1 -> two words: 0x04030201 then 0x08070605, keep 0xF, last 0; each o_vld one cycle after its 4th beat.
- Beats 0xAA, 0xBB(i_last) -> one word 0x0000BBAA, keep 0x3, last 1; next beat 0xCC starts at lane 0.
- i_rdy=0; stream 12 beats -> first word held stable; second completes with acc_done=1 and o_rdy=0 afterwards; release i_rdy -> both words delivered in order, no loss.
- Assert i_reset_n=0 for 1 cycle after 2 beats -> o_vld=0, o_rdy=1; next 4 beats 0x11..0x14 -> 0x14131211, keep 0xF.
- Random i_vld/i_rdy, 1000 beats with random i_last -> scoreboard matches packed model with no duplicates or drops; o_data stable while stalled.
- With STREAM_PACKER_TIMEOUT_EN, TIMEOUT=16: beat 0x5A then idle -> word 0x0000005A, keep 0x1, last 0, o_vld 17 cycles after acceptance. Without the macro -> no output.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream packer and its neighbours.
// Default beat geometry matches the pipe_stage benches.
package stream_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32'd8;
  localparam int unsigned DEFAULT_RATIO = 32'd4;

  // Per-lane valid mask for a word built from DEFAULT_RATIO beats
  typedef logic [DEFAULT_RATIO-1:0] keep_t;

  // Bit offset of a lane inside a packed word
  function automatic int unsigned lane_offset(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Idle timer for the stream packer: counts cycles in which a partial word
// sits in the accumulator without new beats, and fires on the cycle the
// count reaches TIMEOUT so the packer can flush the partial word.
module pack_idle_timer #(
  parameter int unsigned TIMEOUT = 32'd16
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic active_i,   // partial word present and not yet closed
  input  logic beat_i,     // a beat is accepted this cycle
  output logic fire_o      // counter reaches TIMEOUT at the end of this cycle
);

  localparam int unsigned TW = $clog2(TIMEOUT + 32'd1);

  logic [TW-1:0] idle_cnt_q;
  logic [TW-1:0] idle_cnt_d;

  // Next count: clear on any beat or when nothing is pending, saturate at TIMEOUT
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (beat_i || !active_i) begin
      idle_cnt_d = {TW{1'b0}};
    end else if (idle_cnt_q != TW'(TIMEOUT)) begin
      idle_cnt_d = idle_cnt_q + TW'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  assign fire_o = active_i && !beat_i && (idle_cnt_q == TW'(TIMEOUT - 32'd1));

  // Idle counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      idle_cnt_q <= {TW{1'b0}};
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: rtl/stream_packer.sv
// Width up-converter: packs RATIO consecutive WIDTH-bit beats into one
// little-endian WIDTH*RATIO-bit word. i_last closes a word early; the word
// leaves partially filled with a keep mask and o_last set.
// Buffering: one accumulator (which can hold a completed word while the
// output is stalled) plus one output register. o_rdy depends on state only.
// Optional: define STREAM_PACKER_TIMEOUT_EN to flush partial words after
// TIMEOUT idle cycles (instantiates pack_idle_timer).
module stream_packer
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned RATIO   = DEFAULT_RATIO,
  parameter int unsigned TIMEOUT = 32'd16
) (
  input  logic                     clk,
  input  logic                     i_reset_n,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_last,
  input  logic                     i_vld,
  output logic                     o_rdy,
  output logic [WIDTH*RATIO-1:0]   o_data,
  output logic [RATIO-1:0]         o_keep,
  output logic                     o_last,
  output logic                     o_vld,
  input  logic                     i_rdy
);

  localparam int unsigned DW = WIDTH * RATIO;
  localparam int unsigned CW = $clog2(RATIO);

  // Accumulator
  logic [DW-1:0]    acc_data_q, acc_data_d;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d;
  logic [CW-1:0]    acc_cnt_q,  acc_cnt_d;
  logic             acc_last_q, acc_last_d;
  logic             acc_done_q, acc_done_d;

  // Output register
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic             out_vld_q,  out_vld_d;

  logic             accept_s;
  logic             slot_free_s;
  logic             word_end_s;
  logic             flush_s;
  logic [DW-1:0]    beat_data_s;
  logic [RATIO-1:0] beat_keep_s;

  assign o_rdy       = !acc_done_q;
  assign accept_s    = i_vld && !acc_done_q;
  assign slot_free_s = !out_vld_q || i_rdy;
  assign word_end_s  = accept_s && ((acc_cnt_q == CW'(RATIO - 32'd1)) || i_last);

  assign o_data = out_data_q;
  assign o_keep = out_keep_q;
  assign o_last = out_last_q;
  assign o_vld  = out_vld_q;

`ifdef STREAM_PACKER_TIMEOUT_EN
  logic idle_active_s;
  assign idle_active_s = (acc_cnt_q != {CW{1'b0}}) && !acc_done_q;

  pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .active_i  (idle_active_s),
    .beat_i    (accept_s),
    .fire_o    (flush_s)
  );
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT);
  assign flush_s          = 1'b0;
`endif

  // Accumulator contents with the incoming beat merged into its lane
  always_comb begin
    beat_data_s = acc_data_q;
    beat_keep_s = acc_keep_q;
    beat_data_s[lane_offset(32'(acc_cnt_q), WIDTH) +: WIDTH] = i_data;
    beat_keep_s[acc_cnt_q] = 1'b1;
  end

  // Next state: drain output, move held/completed words, accumulate beats
  always_comb begin
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    acc_cnt_d  = acc_cnt_q;
    acc_last_d = acc_last_q;
    acc_done_d = acc_done_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q;

    if (out_vld_q && i_rdy) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end

    if (acc_done_q) begin
      // Held word moves out as soon as the slot frees; no beat is accepted meanwhile
      if (slot_free_s) begin
        out_data_d = acc_data_q;
        out_keep_d = acc_keep_q;
        out_last_d = acc_last_q;
        out_vld_d  = 1'b1;
        acc_data_d = {DW{1'b0}};
        acc_keep_d = {RATIO{1'b0}};
        acc_cnt_d  = {CW{1'b0}};
        acc_last_d = 1'b0;
        acc_done_d = 1'b0;
      end else begin
        acc_done_d = 1'b1;
      end
    end else if (word_end_s) begin
      if (slot_free_s) begin
        out_data_d = beat_data_s;
        out_keep_d = beat_keep_s;
        out_last_d = i_last;
        out_vld_d  = 1'b1;
        acc_data_d = {DW{1'b0}};
        acc_keep_d = {RATIO{1'b0}};
        acc_cnt_d  = {CW{1'b0}};
        acc_last_d = 1'b0;
      end else begin
        acc_data_d = beat_data_s;
        acc_keep_d = beat_keep_s;
        acc_cnt_d  = {CW{1'b0}};
        acc_last_d = i_last;
        acc_done_d = 1'b1;
      end
    end else if (accept_s) begin
      acc_data_d = beat_data_s;
      acc_keep_d = beat_keep_s;
      acc_cnt_d  = acc_cnt_q + CW'(1);
    end else if (flush_s) begin
      // Idle timeout closes the partial word without a last flag
      if (slot_free_s) begin
        out_data_d = acc_data_q;
        out_keep_d = acc_keep_q;
        out_last_d = 1'b0;
        out_vld_d  = 1'b1;
        acc_data_d = {DW{1'b0}};
        acc_keep_d = {RATIO{1'b0}};
        acc_cnt_d  = {CW{1'b0}};
        acc_last_d = 1'b0;
      end else begin
        acc_last_d = 1'b0;
        acc_done_d = 1'b1;
      end
    end else begin
      acc_done_d = acc_done_q;
    end
  end

  // State registers, synchronous active-low reset discards any partial word
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      acc_data_q <= {DW{1'b0}};
      acc_keep_q <= {RATIO{1'b0}};
      acc_cnt_q  <= {CW{1'b0}};
      acc_last_q <= 1'b0;
      acc_done_q <= 1'b0;
      out_data_q <= {DW{1'b0}};
      out_keep_q <= {RATIO{1'b0}};
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_last_q <= acc_last_d;
      acc_done_q <= acc_done_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer (WIDTH=8, RATIO=4, TIMEOUT=16).
// A monitor builds expected words from accepted beats and compares them
// against delivered words; directed sections check latency, stalls, reset
// and the idle flush (behaviour depends on STREAM_PACKER_TIMEOUT_EN).
module tb_stream_packer;
  import stream_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    keep_t       k;
    logic        l;
  } exp_t;

  logic        clk;
  logic        i_reset_n;
  logic [7:0]  i_data;
  logic        i_last;
  logic        i_vld;
  logic        o_rdy;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_last;
  logic        o_vld;
  logic        i_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t        q[$];
  logic [31:0] m_data;
  keep_t       m_keep;
  int          m_cnt;
  int          beats_acc = 0;
  int          words_exp = 0;
  int          words_out = 0;
  logic        stall_prev;
  logic [31:0] held_data;

  stream_packer #(
    .WIDTH   (8),
    .RATIO   (4),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_data    (i_data),
    .i_last    (i_last),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .o_data    (o_data),
    .o_keep    (o_keep),
    .o_last    (o_last),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    i_vld  = 1'b1;
    i_data = d;
    i_last = l;
    @(negedge clk);
    while (!o_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_rdy) chk("send_rdy", 32'(o_rdy), 32'd1);
    @(posedge clk);
    #1;
    i_vld  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  // Monitor: sample at negedge, score output words and model accepted beats
  initial begin
    m_data = 32'd0; m_keep = 4'd0; m_cnt = 0; stall_prev = 1'b0; held_data = 32'd0;
    forever begin
      @(negedge clk);
      if (!i_reset_n) begin
        m_data = 32'd0; m_keep = 4'd0; m_cnt = 0;
        q.delete();
        words_exp = words_out;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_vld", 32'(o_vld), 32'd1);
          chk("hold_data", o_data, held_data);
        end
        stall_prev = o_vld && !i_rdy;
        held_data  = o_data;
        if (o_vld && i_rdy) begin
          words_out++;
          if (q.size() == 0) begin
            chk("unexpected_word", 32'(q.size()), 32'd1);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("word_data", o_data, e.d);
            chk("word_keep", 32'(o_keep), 32'(e.k));
            chk("word_last", 32'(o_last), 32'(e.l));
          end
        end
        if (i_vld && o_rdy) begin
          beats_acc++;
          m_data[m_cnt*8 +: 8] = i_data;
          m_keep[m_cnt]        = 1'b1;
          m_cnt++;
          if (m_cnt == 4 || i_last) begin
            q.push_back('{d: m_data, k: m_keep, l: i_last});
            words_exp++;
            m_data = 32'd0; m_keep = 4'd0; m_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    int start;
    int n;
    logic saw;
    i_reset_n = 1'b0; i_vld = 1'b0; i_data = 8'd0; i_last = 1'b0; i_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    chk("rst_vld",  32'(o_vld),  32'd0);
    chk("rst_rdy",  32'(o_rdy),  32'd1);
    chk("rst_data", o_data,      32'd0);
    chk("rst_keep", 32'(o_keep), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);

    // Two full words with latency checks
    for (int i = 1; i <= 3; i++) send_beat(8'(i), 1'b0);
    chk("lat_early", 32'(o_vld), 32'd0);
    send_beat(8'h04, 1'b0);
    chk("lat_w0", 32'(o_vld), 32'd1);
    chk("lat_w0_data", o_data, 32'h04030201);
    for (int i = 5; i <= 7; i++) send_beat(8'(i), 1'b0);
    send_beat(8'h08, 1'b0);
    chk("lat_w1", 32'(o_vld), 32'd1);
    chk("lat_w1_data", o_data, 32'h08070605);
    wait_drain();

    // Early close, lane restart, single-beat packet
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    chk("part_vld",  32'(o_vld),  32'd1);
    chk("part_keep", 32'(o_keep), 32'h3);
    send_beat(8'hCC, 1'b0);
    send_beat(8'hDD, 1'b0);
    send_beat(8'hEE, 1'b0);
    send_beat(8'hFF, 1'b1);
    send_beat(8'h77, 1'b1);
    wait_drain();

    // Output stall: 12 beats with i_rdy low, then release
    i_rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_beat(8'(8'h21 + i), 1'b0);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("stall_rdy",  32'(o_rdy),  32'd0);
        chk("stall_vld",  32'(o_vld),  32'd1);
        chk("stall_data", o_data,      32'h24232221);
        chk("stall_keep", 32'(o_keep), 32'hF);
        i_rdy = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-packet discards partial data
    send_beat(8'h99, 1'b0);
    send_beat(8'h98, 1'b0);
    i_reset_n = 1'b0;
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    chk("mrst_vld",  32'(o_vld),  32'd0);
    chk("mrst_rdy",  32'(o_rdy),  32'd1);
    chk("mrst_keep", 32'(o_keep), 32'd0);
    for (int i = 0; i < 4; i++) send_beat(8'(8'h11 + i), 1'b0);
    chk("mrst_data", o_data, 32'h14131211);
    wait_drain();

    // Random traffic
    start = beats_acc;
    for (int cyc = 0; cyc < 20000 && beats_acc < start + 1000; cyc++) begin
      i_vld  = ($urandom_range(0, 3) != 0);
      i_data = 8'($urandom);
      i_last = ($urandom_range(0, 4) == 0);
      i_rdy  = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    i_vld = 1'b0; i_last = 1'b0; i_rdy = 1'b1;
    chk("rand_beats", 32'(beats_acc - start >= 1000), 32'd1);
    send_beat(8'hE0, 1'b1);
    wait_drain();

    // Idle partial word
    send_beat(8'h5A, 1'b0);
`ifdef STREAM_PACKER_TIMEOUT_EN
    m_data = 32'd0; m_keep = 4'd0; m_cnt = 0;
    q.push_back('{d: 32'h0000005A, k: 4'h1, l: 1'b0});
    words_exp++;
    n = 1;
    while (!o_vld && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("timeout_latency", 32'(n), 32'd17);
    wait_drain();
`else
    saw = 1'b0;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      saw = saw | o_vld;
      n++;
    end
    chk("no_timeout", 32'(saw), 32'd0);
    send_beat(8'h5B, 1'b1);
    wait_drain();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("word_count", 32'(words_out), 32'(words_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
